hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard control for the 5-stage RV32I core; drives the stall/flush inputs the controller and datapath consume.
//  Tracks destination registers of in-flight instructions (E/M/W) in an internal scoreboard pipeline.
//  From it produces load-use stalls, taken-branch/jump flushes and ALU operand forwarding selects.
//  Keeps saturating stall/flush event counters for performance debug.
// PARAMETERS
//  REG_AW    5      register-index width
//  CNT_W     16     width of each performance counter
//  LOAD_SRC  2'b01  ResultSrc encoding meaning "result from data memory" (load)
// PORTS
//  clk         in   1       core clock
//  reset       in   1       synchronous, active-high reset
//  Rs1D        in   REG_AW  rs1 of instruction in Decode
//  Rs2D        in   REG_AW  rs2 of instruction in Decode
//  RdD         in   REG_AW  rd of instruction in Decode
//  RegWriteD   in   1       Decode instruction writes rd
//  ResultSrcD  in   2       Decode result-source select
//  PCSrcE      in   1       taken branch/jump resolved in Execute
//  StallF      out  1       hold PC register
//  StallD      out  1       hold IF/ID register
//  FlushD      out  1       clear IF/ID register
//  FlushE      out  1       clear ID/EX register (feeds controller FlushE)
//  ForwardAE   out  2       SrcA select: 00 reg file, 01 ResultW, 10 ALUResultM
//  ForwardBE   out  2       SrcB select: same encoding
//  StallCnt    out  CNT_W   load-use stall cycles since reset, saturating
//  FlushCnt    out  CNT_W   control-flush cycles since reset, saturating
// BEHAVIOUR
//  Scoreboard regs: E {Rs1E,Rs2E,RdE,RegWriteE,LoadE}; M {RdM,RegWriteM}; W {RdW,RegWriteW}.
//  Every cycle: E<-D inputs (LoadE = ResultSrcD==LOAD_SRC), M<-E, W<-M; no enables.
//  When FlushE=1, E stage loads zeros (bubble: RegWriteE=0, LoadE=0, RdE=0) instead of D inputs.
//  lwStall = LoadE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE) & !PCSrcE.
//  StallF = StallD = lwStall; FlushD = PCSrcE; FlushE = lwStall | PCSrcE (all combinational).
//  PCSrcE has priority: taken branch in E cancels any stall that cycle (Decode is discarded anyway).
//  ForwardAE: 10 if Rs1E!=0 & RegWriteM & Rs1E==RdM; else 01 if Rs1E!=0 & RegWriteW & Rs1E==RdW; else 00.
//  ForwardBE: identical using Rs2E. M has priority over W when both match (youngest value wins).
//  x0 never forwarded, never causes stall, regardless of RegWrite.
//  Forwarding latency: producer in E at cycle n -> consumer in E at n+1 sees 10, at n+2 sees 01.
//  Load-use: load in E, dependent in D -> exactly one stall cycle, then ForwardxE=01 from W.
//  StallCnt += 1 each cycle lwStall=1; FlushCnt += 1 each cycle PCSrcE=1; both hold at 2^CNT_W-1.
//  Reset (sync): all scoreboard regs and counters to 0. While reset=1: StallF=StallD=0,
//   FlushD=FlushE=1, ForwardAE=ForwardBE=00, counters do not increment.
//  Reset deasserted mid-operation: first cycle after reset sees an empty pipeline (no forwards, no stalls).
// STRUCTURE
//  Shared package: ResultSrc encodings (incl. LOAD_SRC), forward-select constants FWD_RF/FWD_W/FWD_M.
//  Scoreboard stage registers use the existing flopenrc (en=1, clr=FlushE for E stage, clr=0 after).
//  One natural sub-module: hazard_sat_counter (CNT_W, inc, reset) instantiated twice.
// TESTING
//  add x5 then sub x6,x5,x1 back-to-back -> 2nd in E: ForwardAE=10, no stall.
//  add x5; nop; or x7,x2,x5 -> or in E: ForwardBE=01; with x5 written in both M and W -> 10.
//  lw x5 then add x6,x5,x5 -> one cycle StallF=StallD=FlushE=1, then ForwardAE=ForwardBE=01; StallCnt=1.
//  beq taken (PCSrcE=1) with load-use pattern present in D -> FlushD=FlushE=1, StallF=StallD=0; FlushCnt+1.
//  lw x0 / add x0 producers, consumer reads x0 -> no stall, Forward=00.
//  Hold reset 3 cycles mid-stream -> FlushD=FlushE=1, counters frozen then 0; next cycle Forward=00.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the RV32I hazard unit: result-source selects and
// ALU operand forwarding selects.
package hazard_unit_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Memory stage holds the youngest value, so it wins over Writeback.
  function automatic logic [1:0] fwdSel(input logic hitM, input logic hitW);
    if (hitM)      return FWD_M;
    else if (hitW) return FWD_W;
    else           return FWD_RF;
  endfunction

endpackage

// File: rtl/flopenrc.sv
// Resettable flop with enable and synchronous clear, used for pipeline registers.
module flopenrc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)      q <= '0;
    else if (en) begin
      if (clear)    q <= '0;
      else          q <= d;
    end
  end

endmodule

// File: rtl/hazard_sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)                     count <= '0;
    else if (inc && (count != '1)) count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard control for the 5-stage core: tracks in-flight destination registers
// to produce load-use stalls, branch flushes, forwarding selects and perf counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int         REG_AW   = 5,
  parameter int         CNT_W    = 16,
  parameter logic [1:0] LOAD_SRC = RES_MEM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic              PCSrcE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  localparam int EW = 3 * REG_AW + 2;
  localparam int MW = REG_AW + 1;

  logic [EW-1:0]     eD, eQ;
  logic [MW-1:0]     mQ, wQ;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE, RdM, RdW;
  logic              RegWriteE, LoadE, RegWriteM, RegWriteW;
  logic              lwStall, flushEvt;

  assign eD = {Rs1D, Rs2D, RdD, RegWriteD, (ResultSrcD == LOAD_SRC)};

  // A flushed Execute stage becomes a bubble that writes nothing.
  flopenrc #(.WIDTH(EW)) eReg (
    .clk(clk), .reset(reset), .en(1'b1), .clear(FlushE), .d(eD), .q(eQ)
  );
  flopenrc #(.WIDTH(MW)) mReg (
    .clk(clk), .reset(reset), .en(1'b1), .clear(1'b0), .d({RdE, RegWriteE}), .q(mQ)
  );
  flopenrc #(.WIDTH(MW)) wReg (
    .clk(clk), .reset(reset), .en(1'b1), .clear(1'b0), .d({RdM, RegWriteM}), .q(wQ)
  );

  assign {Rs1E, Rs2E, RdE, RegWriteE, LoadE} = eQ;
  assign {RdM, RegWriteM} = mQ;
  assign {RdW, RegWriteW} = wQ;

  // While reset is held the scoreboard may still show stale state, so gate it.
  always_comb begin
    lwStall  = !reset && LoadE && (RdE != '0) &&
               ((Rs1D == RdE) || (Rs2D == RdE)) && !PCSrcE;
    flushEvt = !reset && PCSrcE;
    StallF   = lwStall;
    StallD   = lwStall;
    FlushD   = reset || PCSrcE;
    FlushE   = reset || lwStall || PCSrcE;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!reset) begin
      ForwardAE = fwdSel((Rs1E != '0) && RegWriteM && (Rs1E == RdM),
                         (Rs1E != '0) && RegWriteW && (Rs1E == RdW));
      ForwardBE = fwdSel((Rs2E != '0) && RegWriteM && (Rs2E == RdM),
                         (Rs2E != '0) && RegWriteW && (Rs2E == RdW));
    end
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) stallCounter (
    .clk(clk), .reset(reset), .inc(lwStall), .count(StallCnt)
  );
  hazard_sat_counter #(.CNT_W(CNT_W)) flushCounter (
    .clk(clk), .reset(reset), .inc(flushEvt), .count(FlushCnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, load-use stall, branch flush,
// x0 handling, mid-stream reset and counter saturation (narrow counters).
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    Rs1D = '0, Rs2D = '0, RdD = '0;
  logic          RegWriteD = 1'b0;
  logic [1:0]    ResultSrcD = RES_ALU;
  logic          PCSrcE = 1'b0;
  logic          StallF, StallD, FlushD, FlushE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [CW-1:0] StallCnt, FlushCnt;

  int checks = 0;
  int passes = 0;

  hazard_unit #(.REG_AW(5), .CNT_W(CW), .LOAD_SRC(RES_MEM)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  task automatic setD(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic rw, input logic [1:0] src, input logic pc);
    Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; ResultSrcD = src; PCSrcE = pc;
  endtask

  task automatic nop();
    setD(5'd0, 5'd0, 5'd0, 1'b0, RES_ALU, 1'b0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    nop();
    cycle();
    cycle();
    @(negedge clk);
    checks++; if (StallF !== 1'b0) $display("FAIL rst_stallF got %0b exp 0", StallF); else passes++;
    checks++; if (StallD !== 1'b0) $display("FAIL rst_stallD got %0b exp 0", StallD); else passes++;
    checks++; if (FlushD !== 1'b1) $display("FAIL rst_flushD got %0b exp 1", FlushD); else passes++;
    checks++; if (FlushE !== 1'b1) $display("FAIL rst_flushE got %0b exp 1", FlushE); else passes++;
    checks++; if (ForwardAE !== 2'b00) $display("FAIL rst_fwdA got %b exp 00", ForwardAE); else passes++;
    checks++; if (ForwardBE !== 2'b00) $display("FAIL rst_fwdB got %b exp 00", ForwardBE); else passes++;
    checks++; if (StallCnt !== 3'd0) $display("FAIL rst_stallCnt got %0d exp 0", StallCnt); else passes++;
    checks++; if (FlushCnt !== 3'd0) $display("FAIL rst_flushCnt got %0d exp 0", FlushCnt); else passes++;
    cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (FlushE !== 1'b0) $display("FAIL rst_idle_flushE got %0b exp 0", FlushE); else passes++;
    checks++; if (FlushD !== 1'b0) $display("FAIL rst_idle_flushD got %0b exp 0", FlushD); else passes++;
    cycle();
  endtask

  task automatic test_fwd_mem();
    setD(5'd1, 5'd2, 5'd5, 1'b1, RES_ALU, 1'b0);  // add x5,x1,x2
    cycle();
    setD(5'd5, 5'd1, 5'd6, 1'b1, RES_ALU, 1'b0);  // sub x6,x5,x1
    @(negedge clk);
    checks++; if (StallF !== 1'b0) $display("FAIL fwdm_nostall got %0b exp 0", StallF); else passes++;
    cycle();
    nop();
    @(negedge clk);
    checks++; if (ForwardAE !== FWD_M) $display("FAIL fwdm_A got %b exp 10", ForwardAE); else passes++;
    checks++; if (ForwardBE !== FWD_RF) $display("FAIL fwdm_B got %b exp 00", ForwardBE); else passes++;
    cycle();
  endtask

  task automatic test_fwd_wb();
    setD(5'd1, 5'd2, 5'd5, 1'b1, RES_ALU, 1'b0);  // add x5
    cycle();
    nop();
    cycle();
    setD(5'd2, 5'd5, 5'd7, 1'b1, RES_ALU, 1'b0);  // or x7,x2,x5
    cycle();
    nop();
    @(negedge clk);
    checks++; if (ForwardBE !== FWD_W) $display("FAIL fwdw_B got %b exp 01", ForwardBE); else passes++;
    checks++; if (ForwardAE !== FWD_RF) $display("FAIL fwdw_A got %b exp 00", ForwardAE); else passes++;
    cycle();
    setD(5'd1, 5'd2, 5'd5, 1'b1, RES_ALU, 1'b0);  // add x5 (will sit in W)
    cycle();
    setD(5'd3, 5'd4, 5'd5, 1'b1, RES_ALU, 1'b0);  // add x5 (will sit in M)
    cycle();
    setD(5'd2, 5'd5, 5'd7, 1'b1, RES_ALU, 1'b0);
    cycle();
    nop();
    @(negedge clk);
    checks++; if (ForwardBE !== FWD_M) $display("FAIL fwd_prio_B got %b exp 10", ForwardBE); else passes++;
    cycle();
  endtask

  task automatic test_load_use();
    nop();
    @(negedge clk);
    checks++; if (StallCnt !== 3'd0) $display("FAIL lu_cnt0 got %0d exp 0", StallCnt); else passes++;
    cycle();
    setD(5'd1, 5'd0, 5'd5, 1'b1, RES_MEM, 1'b0);  // lw x5,0(x1)
    cycle();
    setD(5'd5, 5'd5, 5'd6, 1'b1, RES_ALU, 1'b0);  // add x6,x5,x5
    @(negedge clk);
    checks++; if (StallF !== 1'b1) $display("FAIL lu_stallF got %0b exp 1", StallF); else passes++;
    checks++; if (StallD !== 1'b1) $display("FAIL lu_stallD got %0b exp 1", StallD); else passes++;
    checks++; if (FlushE !== 1'b1) $display("FAIL lu_flushE got %0b exp 1", FlushE); else passes++;
    checks++; if (FlushD !== 1'b0) $display("FAIL lu_flushD got %0b exp 0", FlushD); else passes++;
    cycle();
    @(negedge clk);
    checks++; if (StallF !== 1'b0) $display("FAIL lu_one_stall got %0b exp 0", StallF); else passes++;
    checks++; if (ForwardAE !== FWD_RF) $display("FAIL lu_bubble_fwd got %b exp 00", ForwardAE); else passes++;
    cycle();
    nop();
    @(negedge clk);
    checks++; if (ForwardAE !== FWD_W) $display("FAIL lu_fwdA got %b exp 01", ForwardAE); else passes++;
    checks++; if (ForwardBE !== FWD_W) $display("FAIL lu_fwdB got %b exp 01", ForwardBE); else passes++;
    checks++; if (StallCnt !== 3'd1) $display("FAIL lu_cnt got %0d exp 1", StallCnt); else passes++;
    cycle();
  endtask

  task automatic test_branch_flush();
    setD(5'd1, 5'd0, 5'd5, 1'b1, RES_MEM, 1'b0);  // lw x5
    cycle();
    setD(5'd5, 5'd1, 5'd6, 1'b1, RES_ALU, 1'b1);  // dependent in D, taken branch in E
    @(negedge clk);
    checks++; if (FlushD !== 1'b1) $display("FAIL br_flushD got %0b exp 1", FlushD); else passes++;
    checks++; if (FlushE !== 1'b1) $display("FAIL br_flushE got %0b exp 1", FlushE); else passes++;
    checks++; if (StallF !== 1'b0) $display("FAIL br_stallF got %0b exp 0", StallF); else passes++;
    checks++; if (StallD !== 1'b0) $display("FAIL br_stallD got %0b exp 0", StallD); else passes++;
    checks++; if (FlushCnt !== 3'd0) $display("FAIL br_cnt_before got %0d exp 0", FlushCnt); else passes++;
    cycle();
    nop();
    @(negedge clk);
    checks++; if (FlushCnt !== 3'd1) $display("FAIL br_cnt got %0d exp 1", FlushCnt); else passes++;
    checks++; if (StallCnt !== 3'd1) $display("FAIL br_stallcnt got %0d exp 1", StallCnt); else passes++;
    checks++; if (FlushE !== 1'b0) $display("FAIL br_after_flushE got %0b exp 0", FlushE); else passes++;
    cycle();
  endtask

  task automatic test_x0();
    setD(5'd0, 5'd0, 5'd0, 1'b1, RES_MEM, 1'b0);  // lw x0,0(x0)
    cycle();
    setD(5'd0, 5'd0, 5'd0, 1'b1, RES_ALU, 1'b0);  // add x0,x0,x0
    @(negedge clk);
    checks++; if (StallF !== 1'b0) $display("FAIL x0_nostall got %0b exp 0", StallF); else passes++;
    cycle();
    setD(5'd0, 5'd0, 5'd6, 1'b1, RES_ALU, 1'b0);  // add x6,x0,x0
    cycle();
    nop();
    @(negedge clk);
    checks++; if (ForwardAE !== FWD_RF) $display("FAIL x0_fwdA got %b exp 00", ForwardAE); else passes++;
    checks++; if (ForwardBE !== FWD_RF) $display("FAIL x0_fwdB got %b exp 00", ForwardBE); else passes++;
    cycle();
  endtask

  task automatic test_reset_mid();
    setD(5'd1, 5'd2, 5'd5, 1'b1, RES_ALU, 1'b0);  // add x5
    cycle();
    setD(5'd5, 5'd0, 5'd7, 1'b1, RES_MEM, 1'b0);  // lw x7,0(x5)
    cycle();
    setD(5'd7, 5'd5, 5'd8, 1'b1, RES_ALU, 1'b0);  // add x8,x7,x5
    @(negedge clk);
    checks++; if (StallF !== 1'b1) $display("FAIL rm_pre_stall got %0b exp 1", StallF); else passes++;
    checks++; if (ForwardAE !== FWD_M) $display("FAIL rm_pre_fwd got %b exp 10", ForwardAE); else passes++;
    reset = 1'b1;
    #1;
    checks++; if (StallF !== 1'b0) $display("FAIL rm_stallF got %0b exp 0", StallF); else passes++;
    checks++; if (FlushD !== 1'b1) $display("FAIL rm_flushD got %0b exp 1", FlushD); else passes++;
    checks++; if (FlushE !== 1'b1) $display("FAIL rm_flushE got %0b exp 1", FlushE); else passes++;
    checks++; if (ForwardAE !== FWD_RF) $display("FAIL rm_fwdA got %b exp 00", ForwardAE); else passes++;
    checks++; if (StallCnt !== 3'd1) $display("FAIL rm_frozen_stall got %0d exp 1", StallCnt); else passes++;
    checks++; if (FlushCnt !== 3'd1) $display("FAIL rm_frozen_flush got %0d exp 1", FlushCnt); else passes++;
    cycle();
    @(negedge clk);
    checks++; if (StallCnt !== 3'd0) $display("FAIL rm_clr_stall got %0d exp 0", StallCnt); else passes++;
    checks++; if (FlushCnt !== 3'd0) $display("FAIL rm_clr_flush got %0d exp 0", FlushCnt); else passes++;
    cycle();
    cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (StallF !== 1'b0) $display("FAIL rm_post_stall got %0b exp 0", StallF); else passes++;
    checks++; if (FlushE !== 1'b0) $display("FAIL rm_post_flushE got %0b exp 0", FlushE); else passes++;
    cycle();
    nop();
    @(negedge clk);
    checks++; if (ForwardAE !== FWD_RF) $display("FAIL rm_post_fwdA got %b exp 00", ForwardAE); else passes++;
    checks++; if (ForwardBE !== FWD_RF) $display("FAIL rm_post_fwdB got %b exp 00", ForwardBE); else passes++;
    cycle();
  endtask

  task automatic test_saturation();
    // lw x5,0(x5) repeated: stalls on every other cycle.
    setD(5'd5, 5'd0, 5'd5, 1'b1, RES_MEM, 1'b0);
    for (int i = 0; i < 12; i++) cycle();
    @(negedge clk);
    checks++; if (StallCnt !== 3'd6) $display("FAIL sat_stall_mid got %0d exp 6", StallCnt); else passes++;
    for (int i = 0; i < 8; i++) cycle();
    @(negedge clk);
    checks++; if (StallCnt !== 3'd7) $display("FAIL sat_stall got %0d exp 7", StallCnt); else passes++;
    setD(5'd5, 5'd0, 5'd5, 1'b1, RES_MEM, 1'b1);
    for (int i = 0; i < 10; i++) cycle();
    nop();
    @(negedge clk);
    checks++; if (FlushCnt !== 3'd7) $display("FAIL sat_flush got %0d exp 7", FlushCnt); else passes++;
    checks++; if (StallCnt !== 3'd7) $display("FAIL sat_stall_hold got %0d exp 7", StallCnt); else passes++;
    cycle();
  endtask

  initial begin
    test_reset();
    test_fwd_mem();
    test_fwd_wb();
    test_load_use();
    test_branch_flush();
    test_x0();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
